// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
//
// Pops words from an upstream FIFO and hands them downstream through a
// valid/ready interface. The module tracks the FIFO occupancy itself by
// watching the FIFO's write strobe and its own pop strobe. A 3-entry output
// buffer absorbs the one-cycle FIFO read latency, so one word per cycle can
// be sustained.
//
// Ports
//   CLK           clock, all state on the rising edge
//   RESET         asynchronous, active-high reset
//   FIFO_WRITE    write strobe seen by the upstream FIFO (one word per cycle)
//   FIFO_DATA     FIFO read data, valid the cycle after FIFO_READ
//   FIFO_READ     pop strobe to the FIFO
//   ENABLE        permits new pops when high
//   DATA_OUT      head word of the output buffer (0 when VALID_OUT is low)
//   VALID_OUT     DATA_OUT holds a word
//   READY_IN      downstream accepts; transfer on VALID_OUT && READY_IN
//   COUNT         tracked FIFO occupancy, 0..DEPTH
//   ALMOST_EMPTY  COUNT <= LOW_MARK
//   errOverflow   sticky: write seen while the FIFO was full
//   STATE         0 IDLE, 1 ACTIVE, 2 STALL
// ---------------------------------------------------------------------------
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int LOW_MARK   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FIFO_WRITE,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA,
    output logic                  FIFO_READ,
    input  logic                  ENABLE,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  VALID_OUT,
    input  logic                  READY_IN,
    output logic [3:0]            COUNT,
    output logic                  ALMOST_EMPTY,
    output logic                  errOverflow,
    output logic [1:0]            STATE
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [3:0] LOW_C   = 4'(LOW_MARK);

    logic [3:0]            count_q, count_d;
    logic                  err_q, err_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            bufcnt_q, bufcnt_d;
    logic [DATA_WIDTH-1:0] buf_q [3];
    logic [DATA_WIDTH-1:0] buf_d [3];
    state_t                state_q, state_d;

    logic                  fifo_read;
    logic                  xfer;
    logic [2:0]            occupancy;

    // Pop decision uses registered state plus ENABLE only. Counting the
    // in-flight word guarantees a free buffer slot when it lands.
    always_comb begin
        occupancy = {1'b0, bufcnt_q} + {2'b00, inflight_q};
        fifo_read = ENABLE && (count_q != 4'd0) && (occupancy < 3'd3);
    end

    assign xfer = (bufcnt_q != 2'd0) && READY_IN;

    // Occupancy tracking. A pop is never issued at zero occupancy, so only
    // the full case needs guarding.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        case ({FIFO_WRITE, fifo_read})
            2'b10: begin
                if (count_q == DEPTH_C) begin
                    err_d = 1'b1;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    // Output buffer: drop the head on transfer first, then append the word
    // arriving from the FIFO behind whatever remains.
    always_comb begin
        buf_d[0]   = buf_q[0];
        buf_d[1]   = buf_q[1];
        buf_d[2]   = buf_q[2];
        bufcnt_d   = bufcnt_q;
        inflight_d = fifo_read;
        if (xfer) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
            bufcnt_d = bufcnt_q - 2'd1;
        end
        if (inflight_q) begin
            case (bufcnt_d)
                2'd0:    buf_d[0] = FIFO_DATA;
                2'd1:    buf_d[1] = FIFO_DATA;
                default: buf_d[2] = FIFO_DATA;
            endcase
            bufcnt_d = bufcnt_d + 2'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_read) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (bufcnt_d == 2'd3) begin
                    state_d = ST_STALL;
                end else if ((bufcnt_d == 2'd0) && !inflight_d) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (xfer) state_d = ST_ACTIVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q    <= 4'd0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
            bufcnt_q   <= 2'd0;
            state_q    <= ST_IDLE;
        end else begin
            count_q    <= count_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
            bufcnt_q   <= bufcnt_d;
            state_q    <= state_d;
        end
    end

    // Buffer storage needs no reset: DATA_OUT is masked by VALID_OUT.
    always_ff @(posedge CLK) begin
        buf_q[0] <= buf_d[0];
        buf_q[1] <= buf_d[1];
        buf_q[2] <= buf_d[2];
    end

    assign FIFO_READ    = fifo_read;
    assign VALID_OUT    = (bufcnt_q != 2'd0);
    assign DATA_OUT     = VALID_OUT ? buf_q[0] : '0;
    assign COUNT        = count_q;
    assign ALMOST_EMPTY = (count_q <= LOW_C);
    assign errOverflow  = err_q;
    assign STATE        = state_q;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

    localparam int DEPTH    = 8;
    localparam int LOW_MARK = 2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       FIFO_WRITE;
    logic [7:0] FIFO_DATA;
    logic       FIFO_READ;
    logic       ENABLE;
    logic [7:0] DATA_OUT;
    logic       VALID_OUT;
    logic       READY_IN;
    logic [3:0] COUNT;
    logic       ALMOST_EMPTY;
    logic       errOverflow;
    logic [1:0] STATE;

    fifo_reader #(.DATA_WIDTH(8), .DEPTH(DEPTH), .LOW_MARK(LOW_MARK)) dut (
        .CLK(CLK), .RESET(RESET), .FIFO_WRITE(FIFO_WRITE), .FIFO_DATA(FIFO_DATA),
        .FIFO_READ(FIFO_READ), .ENABLE(ENABLE), .DATA_OUT(DATA_OUT),
        .VALID_OUT(VALID_OUT), .READY_IN(READY_IN), .COUNT(COUNT),
        .ALMOST_EMPTY(ALMOST_EMPTY), .errOverflow(errOverflow), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: upstream FIFO contents, output buffer contents,
    // the word travelling between them, and the sticky error.
    logic [7:0] m_fifo[$];
    logic [7:0] m_obuf[$];
    logic [7:0] m_accepted[$];
    logic [7:0] dut_deliv[$];
    int         deliv_cyc[$];
    bit         m_infl;
    logic [7:0] m_infl_word;
    bit         m_err;
    int         cyc_no = 0;

    // Values sampled on the falling edge of the most recent cycle
    logic       s_rd, s_vld, s_ae, s_err;
    logic [7:0] s_dout;
    logic [3:0] s_cnt;
    logic [1:0] s_state;

    typedef struct {
        bit         wr;
        logic [7:0] wd;
        bit         rd;
        bit         vld;
        logic [7:0] dout;
        int         cnt;
        int         st;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (m_obuf.size() == 3) return 2;
        if (m_obuf.size() == 0 && !m_infl) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_obuf.delete();
        m_infl = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        RESET      = 1'b1;
        FIFO_WRITE = 1'b0;
        ENABLE     = 1'b0;
        READY_IN   = 1'b0;
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    // One clock cycle: drive inputs, check every output against the model
    // on the falling edge, advance the model on the rising edge.
    task automatic cyc(input bit wr, input logic [7:0] wd, input bit en, input bit rdy);
        bit exp_rd;
        FIFO_WRITE = wr;
        ENABLE     = en;
        READY_IN   = rdy;
        FIFO_DATA  = m_infl ? m_infl_word : 8'($urandom);
        @(negedge CLK);
        exp_rd  = en && (m_fifo.size() > 0) && ((m_obuf.size() + int'(m_infl)) < 3);
        s_rd    = FIFO_READ;
        s_vld   = VALID_OUT;
        s_dout  = DATA_OUT;
        s_cnt   = COUNT;
        s_ae    = ALMOST_EMPTY;
        s_err   = errOverflow;
        s_state = STATE;
        chk("fifo_read", s_rd, exp_rd);
        chk("valid_out", s_vld, m_obuf.size() > 0);
        chk("data_out", s_dout, (m_obuf.size() > 0) ? m_obuf[0] : 8'h00);
        chk("count", s_cnt, m_fifo.size());
        chk("almost_empty", s_ae, m_fifo.size() <= LOW_MARK);
        chk("err_overflow", s_err, m_err);
        chk("state", s_state, exp_state());
        @(posedge CLK);
        if (s_vld && rdy) begin
            dut_deliv.push_back(s_dout);
            deliv_cyc.push_back(cyc_no);
        end
        if (m_obuf.size() > 0 && rdy) void'(m_obuf.pop_front());
        if (m_infl) m_obuf.push_back(m_infl_word);
        m_infl = exp_rd;
        if (exp_rd) m_infl_word = m_fifo.pop_front();
        if (wr) begin
            if (m_fifo.size() == DEPTH) begin
                m_err = 1'b1;
            end else begin
                m_fifo.push_back(wd);
                m_accepted.push_back(wd);
            end
        end
        cyc_no++;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int pops;
        int n;
        bit wr, en, rdy;

        // ---------------- reset state ----------------
        RESET      = 1'b1;
        FIFO_WRITE = 1'b0;
        ENABLE     = 1'b1;
        READY_IN   = 1'b1;
        FIFO_DATA  = 8'h00;
        model_reset();
        @(negedge CLK);
        chk("rst_fifo_read", FIFO_READ, 0);
        chk("rst_valid", VALID_OUT, 0);
        chk("rst_data", DATA_OUT, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_almost_empty", ALMOST_EMPTY, 1);
        chk("rst_err", errOverflow, 0);
        chk("rst_state", STATE, 0);
        do_reset();

        // ---------------- three words, table driven ----------------
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 0, 0};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1, 0};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1, 1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1, 1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 0, 1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 0, 1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 0};
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].wr, tbl[i].wd, 1'b1, 1'b1);
            chk($sformatf("tbl%0d_rd", i), s_rd, tbl[i].rd);
            chk($sformatf("tbl%0d_vld", i), s_vld, tbl[i].vld);
            chk($sformatf("tbl%0d_dout", i), s_dout, tbl[i].dout);
            chk($sformatf("tbl%0d_cnt", i), s_cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d_state", i), s_state, tbl[i].st);
        end

        // ---------------- fill 8 with downstream stalled ----------------
        do_reset();
        dut_deliv.delete();
        deliv_cyc.delete();
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
            pops += int'(s_rd);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            pops += int'(s_rd);
            chk("stall_head_stable", s_dout, 8'hA0);
        end
        chk("stall_pops", pops, 3);
        chk("stall_state", s_state, 2);
        chk("stall_count", s_cnt, 5);
        chk("stall_valid", s_vld, 1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("stall_deliv_n", dut_deliv.size(), 8);
        n = (dut_deliv.size() < 8) ? dut_deliv.size() : 8;
        for (int i = 0; i < n; i++) chk($sformatf("stall_deliv%0d", i), dut_deliv[i], 8'hA0 + 8'(i));
        if (n == 8) chk("stall_back_to_back", deliv_cyc[7] - deliv_cyc[0], 7);
        chk("stall_final_state", STATE, 0);

        // ---------------- overflow ----------------
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_no_pop", s_rd, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_err_set", s_err, 1);
        chk("ovf_count_held", s_cnt, 8);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_err_sticky", s_err, 1);

        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_rw_pop", s_rd, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_rw_no_err", s_err, 0);
        chk("full_rw_count", s_cnt, 8);

        // ---------------- ENABLE dropped after a pop ----------------
        do_reset();
        dut_deliv.delete();
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("en_pop", s_rd, 1);
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
            pops += int'(s_rd);
        end
        chk("en_low_no_pop", pops, 0);
        chk("en_deliv_n", dut_deliv.size(), 1);
        if (dut_deliv.size() > 0) chk("en_deliv_word", dut_deliv[0], 8'hC0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("en_resume_pop", s_rd, 1);

        // ---------------- asynchronous reset mid-stream ----------------
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        ENABLE = 1'b0;
        @(negedge CLK);
        chk("pre_rst_valid", VALID_OUT, 1);
        chk("pre_rst_count", COUNT, 6);
        chk("pre_rst_err", errOverflow, 1);
        #2 RESET = 1'b1;
        #1;
        chk("arst_valid", VALID_OUT, 0);
        chk("arst_data", DATA_OUT, 0);
        chk("arst_count", COUNT, 0);
        chk("arst_err", errOverflow, 0);
        chk("arst_state", STATE, 0);
        chk("arst_almost_empty", ALMOST_EMPTY, 1);
        chk("arst_fifo_read", FIFO_READ, 0);
        model_reset();
        @(posedge CLK);
        #1 RESET = 1'b0;

        // ---------------- ALMOST_EMPTY sweep ----------------
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 8'(k), 1'b0, 1'b0);
            chk($sformatf("ae_count%0d", k), s_cnt, k);
            chk($sformatf("ae_flag%0d", k), s_ae, k <= LOW_MARK);
        end

        // ---------------- randomized traffic ----------------
        do_reset();
        dut_deliv.delete();
        m_accepted.delete();
        for (int i = 0; i < 3000; i++) begin
            if (m_fifo.size() == DEPTH) wr = ($urandom_range(0, 99) < 5);
            else                        wr = ($urandom_range(0, 99) < 60);
            en  = ($urandom_range(0, 99) < 80);
            rdy = ($urandom_range(0, 99) < 70);
            cyc(wr, 8'($urandom), en, rdy);
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("rand_deliv_n", dut_deliv.size(), m_accepted.size());
        n = (dut_deliv.size() < m_accepted.size()) ? dut_deliv.size() : m_accepted.size();
        for (int i = 0; i < n; i++) chk("rand_order", dut_deliv[i], m_accepted[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO word and output data.
REQ-002 Parameter DEPTH, default 8, capacity of the upstream FIFO in words.
REQ-003 Parameter LOW_MARK, default 2, occupancy at or below which ALMOST_EMPTY asserts.
REQ-004 CLK  in  1  single clock, all state on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 FIFO_WRITE  in  1  write strobe as presented to the upstream FIFO; one word enters per high cycle.
REQ-007 FIFO_DATA  in  DATA_WIDTH  FIFO read data, valid in the cycle after FIFO_READ was high.
REQ-008 FIFO_READ  out  1  pop strobe to the FIFO.
REQ-009 ENABLE  in  1  permits new pops when high.
REQ-010 DATA_OUT  out  DATA_WIDTH  head word of the output buffer.
REQ-011 VALID_OUT  out  1  DATA_OUT holds a word.
REQ-012 READY_IN  in  1  downstream accepts; transfer when VALID_OUT and READY_IN high on a rising edge.
REQ-013 COUNT  out  4  tracked FIFO occupancy, 0..DEPTH.
REQ-014 ALMOST_EMPTY  out  1  COUNT <= LOW_MARK.
REQ-015 errOverflow  out  1  sticky: write seen while FIFO full.
REQ-016 STATE  out  2  FSM state: 0 IDLE, 1 ACTIVE, 2 STALL.

Function
REQ-017 COUNT next = COUNT + FIFO_WRITE - FIFO_READ; width rules: never exceeds DEPTH, never below 0.
REQ-018 FIFO_WRITE with COUNT==DEPTH and FIFO_READ low: COUNT holds DEPTH, errOverflow sets next edge.
REQ-019 FIFO_WRITE and FIFO_READ same cycle at COUNT==DEPTH: COUNT unchanged, no error.
REQ-020 errOverflow stays 1 until RESET.
REQ-021 Output buffer: 3-entry in-order queue; BUFCNT = entries held; INFLIGHT = 1 when FIFO_READ was high last cycle.
REQ-022 FIFO_READ = ENABLE && COUNT>0 && (BUFCNT + INFLIGHT) < 3; driven from registered state only, no path from READY_IN or FIFO_WRITE.
REQ-023 FIFO_READ never asserts at COUNT==0; underflow of the FIFO is impossible by construction.
REQ-024 Latency: FIFO_READ high in cycle n -> FIFO_DATA captured at edge ending n+1 -> VALID_OUT with that word in cycle n+2 if buffer was empty.
REQ-025 Sustained throughput one word per cycle when COUNT>0, ENABLE high, READY_IN high.
REQ-026 Capture and downstream transfer in the same edge: BUFCNT unchanged, order preserved.
REQ-027 DATA_OUT/VALID_OUT stable while VALID_OUT high and READY_IN low.
REQ-028 ENABLE low: no new pops; in-flight word still captured; buffer continues draining.
REQ-029 FSM IDLE: BUFCNT==0 and INFLIGHT==0; ACTIVE: otherwise with BUFCNT<3; STALL: BUFCNT==3.
REQ-030 Transitions: IDLE->ACTIVE on FIFO_READ; ACTIVE->STALL when BUFCNT reaches 3; STALL->ACTIVE on transfer; ACTIVE->IDLE when last word transferred with nothing in flight.
REQ-031 DATA_OUT = 0 whenever VALID_OUT low.

Reset
REQ-032 RESET high asynchronously clears COUNT, BUFCNT, INFLIGHT, errOverflow, VALID_OUT, DATA_OUT, FIFO_READ to 0; STATE=IDLE; ALMOST_EMPTY=1.
REQ-033 Reset mid-operation discards buffered and in-flight words; the FIFO shares RESET so occupancy tracking stays consistent.
REQ-034 First pop possible in the first cycle after RESET deasserts with COUNT>0.

Verification
REQ-035 Write 0x11,0x22,0x33 with READY_IN=1, ENABLE=1 -> DATA_OUT 0x11,0x22,0x33 on consecutive cycles, first 2 cycles after first FIFO_READ; COUNT returns to 0, STATE IDLE.
REQ-036 Fill 8 words, READY_IN=0 -> exactly 3 pops, STATE=STALL, COUNT=5, DATA_OUT holds first word stable; raise READY_IN -> all 8 delivered in order, one per cycle.
REQ-037 COUNT==8, FIFO_WRITE=1, FIFO_READ=0 -> errOverflow=1 next cycle, COUNT=8; same with FIFO_READ=1 -> errOverflow stays 0.
REQ-038 ENABLE dropped in cycle after a pop -> that word still delivered, no further FIFO_READ until ENABLE=1.
REQ-039 RESET asserted mid-stream with BUFCNT=2 -> VALID_OUT, COUNT, errOverflow 0 immediately without a clock edge; STATE=IDLE.
REQ-040 COUNT sweeps 0..4 -> ALMOST_EMPTY=1 for 0..2, 0 for 3..4.
